// File: rtl/inst_fetch_resp_if.sv
// Instruction-fetch bundle between the PC register, the fetch responder and
// the byte-wide instruction memory.
//   slave  : the responder (inst_fetch_resp)
//   master : the requesting side (PC register, pipeline controller, memory)
interface inst_fetch_resp_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) ();

    // Request side from the PC register / pipeline controller
    logic [ADDR_WIDTH-1:0] pc;
    logic                  ce;
    logic [5:0]            stall;

    // Instruction delivered back to the pipeline
    logic [INST_WIDTH-1:0] inst;
    logic                  inst_valid;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  stallreq_if;

    // Byte-wide instruction memory port
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  pc, ce, stall, mem_rdata, mem_ready,
        output inst, inst_valid, inst_pc, stallreq_if, mem_rd, mem_addr
    );

    modport master (
        output pc, ce, stall, mem_rdata, mem_ready,
        input  inst, inst_valid, inst_pc, stallreq_if, mem_rd, mem_addr
    );

endinterface

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder.
// Accepts a PC/ce pair, reads four bytes from a byte-wide instruction memory
// (one byte per accepted beat), assembles them little-endian and presents the
// word with inst_valid. stallreq_if holds the PC until the word is delivered.
// Misaligned PCs are aligned down to a word boundary.
//
// Optional build macro FETCH_BUF_EN: adds a one-entry buffer holding the last
// fetched word; a repeat fetch of the same aligned address is served from it
// without touching memory.
module inst_fetch_resp #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_resp_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [ADDR_WIDTH-1:0] base;
    logic [1:0]            byte_cnt;
    logic [INST_WIDTH-1:0] inst_q;
    logic [ADDR_WIDTH-1:0] inst_pc_q;

    logic [ADDR_WIDTH-1:0] pc_aligned;
    logic                  beat_ok;
    logic                  last_beat;
    logic                  buf_hit;
    logic [INST_WIDTH-1:0] buf_word;
    logic [ADDR_WIDTH-1:0] buf_pc;

    logic                  mem_rd_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic                  inst_valid_c;
    logic                  stallreq_c;

    // Only stall[1] (IF/ID) and the word-aligned PC bits matter here.
    logic                  unused_bits;
    assign unused_bits = ^{bus.stall[5:2], bus.stall[0], bus.pc[1:0]};

    assign pc_aligned = {bus.pc[ADDR_WIDTH-1:2], 2'b00};
    assign beat_ok    = (state == FETCH) && bus.mem_ready;
    assign last_beat  = beat_ok && (byte_cnt == 2'd3);

`ifdef FETCH_BUF_EN
    logic                  buf_valid;
    logic [ADDR_WIDTH-1:0] buf_tag;
    logic [INST_WIDTH-1:0] buf_inst;

    // Buffer valid flag: set by every completed fetch, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
        end else if (last_beat) begin
            buf_valid <= 1'b1;
        end
    end

    // Buffer tag and word: loaded with the word completing this cycle.
    // NOTE: tag and data carry no reset; buf_valid alone decides whether
    // they mean anything, so resetting them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (last_beat) begin
            buf_tag  <= base;
            buf_inst <= {bus.mem_rdata, inst_q[INST_WIDTH-9:0]};
        end
    end

    assign buf_hit  = buf_valid && (buf_tag == pc_aligned);
    assign buf_word = buf_inst;
    assign buf_pc   = buf_tag;
`else
    assign buf_hit  = 1'b0;
    assign buf_word = '0;
    assign buf_pc   = '0;
`endif

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned; that keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.ce) begin
                    state_next = buf_hit ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!bus.stall[1]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: memory request, valid flag and PC stall request.
    always_comb begin
        mem_rd_c     = 1'b0;
        mem_addr_c   = '0;
        inst_valid_c = 1'b0;
        stallreq_c   = bus.ce && (state != DONE);
        unique case (state)
            FETCH: begin
                mem_rd_c   = 1'b1;
                mem_addr_c = base + {{(ADDR_WIDTH-2){1'b0}}, byte_cnt};
            end
            DONE: begin
                inst_valid_c = 1'b1;
            end
            default: begin
                mem_rd_c = 1'b0;
            end
        endcase
    end

    // Fetch datapath: base address, byte counter, word assembly, result PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            base      <= '0;
            byte_cnt  <= 2'd0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.ce) begin
                        base     <= pc_aligned;
                        byte_cnt <= 2'd0;
                        if (buf_hit) begin
                            inst_q    <= buf_word;
                            inst_pc_q <= buf_pc;
                        end
                    end
                end
                FETCH: begin
                    if (bus.mem_ready) begin
                        inst_q[{byte_cnt, 3'b000} +: 8] <= bus.mem_rdata;
                        byte_cnt                        <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            inst_pc_q <= base;
                        end
                    end
                end
                default: begin
                    base <= base;
                end
            endcase
        end
    end

    assign bus.inst        = inst_q;
    assign bus.inst_pc     = inst_pc_q;
    assign bus.inst_valid  = inst_valid_c;
    assign bus.stallreq_if = stallreq_c;
    assign bus.mem_rd      = mem_rd_c;
    assign bus.mem_addr    = mem_addr_c;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Self-checking bench for inst_fetch_resp: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model (memory contents computed from an address hash).
module tb_inst_fetch_resp;

    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_resp_if #(.ADDR_WIDTH(AW), .INST_WIDTH(32)) bus ();

    inst_fetch_resp #(.ADDR_WIDTH(AW), .INST_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Memory image: bytes 0..3 fixed, everything else hashed from the address.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0:   return 8'h13;
            32'h1:   return 8'h05;
            32'h2:   return 8'h10;
            32'h3:   return 8'h00;
            default: return (a[7:0] * 8'd37 + a[15:8] + a[31:24]) ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return {mem_byte(b + 32'd3), mem_byte(b + 32'd2),
                mem_byte(b + 32'd1), mem_byte(b)};
    endfunction

    logic [7:0] noise = 8'h00;
    assign bus.mem_rdata = bus.mem_ready ? mem_byte(bus.mem_addr) : noise;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        noise = 8'($urandom);
    endtask

    // ---------------- behavioural model ----------------
    // A fetch is "in flight" from acceptance until four beats have been
    // accepted; the word is then "on offer" until the IF/ID stall clears.
    bit          m_busy    = 1'b0;
    int          m_beats   = 0;
    bit [31:0]   m_base    = '0;
    bit          m_deliver = 1'b0;
    bit [31:0]   m_pc      = '0;
    bit          m_bv      = 1'b0;
    bit [31:0]   m_btag    = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy    <= 1'b0;
            m_beats   <= 0;
            m_deliver <= 1'b0;
            m_bv      <= 1'b0;
        end else if (m_busy) begin
            if (bus.mem_ready) begin
                m_beats <= m_beats + 1;
                if (m_beats == 3) begin
                    m_busy    <= 1'b0;
                    m_deliver <= 1'b1;
                    m_pc      <= m_base;
                    m_bv      <= 1'b1;
                    m_btag    <= m_base;
                end
            end
        end else if (m_deliver) begin
            if (!bus.stall[1]) m_deliver <= 1'b0;
        end else if (bus.ce) begin
`ifdef FETCH_BUF_EN
            if (m_bv && m_btag == {bus.pc[31:2], 2'b00}) begin
                m_deliver <= 1'b1;
                m_pc      <= {bus.pc[31:2], 2'b00};
            end else begin
                m_busy  <= 1'b1;
                m_beats <= 0;
                m_base  <= {bus.pc[31:2], 2'b00};
            end
`else
            m_busy  <= 1'b1;
            m_beats <= 0;
            m_base  <= {bus.pc[31:2], 2'b00};
`endif
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("mem_rd", 32'(bus.mem_rd), 32'(m_busy));
            check("mem_addr", bus.mem_addr, m_busy ? m_base + 32'(m_beats) : 32'h0);
            check("inst_valid", 32'(bus.inst_valid), 32'(m_deliver));
            check("stallreq_if", 32'(bus.stallreq_if), 32'(bus.ce && !m_deliver));
            if (m_deliver) begin
                check("inst", bus.inst, mem_word(m_pc));
                check("inst_pc", bus.inst_pc, m_pc);
            end
        end
    end

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!bus.inst_valid && n < limit) begin
            step();
            n++;
        end
        check("wait_valid", 32'(bus.inst_valid), 32'h1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int beats;
        logic [31:0] w;

        rst           = 1'b1;
        bus.ce        = 1'b0;
        bus.pc        = '0;
        bus.stall     = '0;
        bus.mem_ready = 1'b0;
        step();
        step();

        // Reset values
        @(negedge clk);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        check("rst_valid", 32'(bus.inst_valid), 32'h0);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);

        // Test 1: pc=0, mem_ready high, literal timing and word.
        step();
        rst           = 1'b0;
        bus.ce        = 1'b1;
        bus.pc        = 32'h0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("t1_stallreq_c0", 32'(bus.stallreq_if), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            step();
            @(negedge clk);
            check("t1_mem_rd", 32'(bus.mem_rd), 32'h1);
            check("t1_mem_addr", bus.mem_addr, 32'(k - 1));
            check("t1_stallreq", 32'(bus.stallreq_if), 32'h1);
        end
        step();
        bus.pc = 32'h4;
        @(negedge clk);
        check("t1_inst", bus.inst, 32'h00100513);
        check("t1_valid", 32'(bus.inst_valid), 32'h1);
        check("t1_inst_pc", bus.inst_pc, 32'h0);
        check("t1_stallreq_c5", 32'(bus.stallreq_if), 32'h0);
        check("t1_mem_rd_c5", 32'(bus.mem_rd), 32'h0);

        // Test 2: pc=4, two wait cycles before each beat.
        step();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            bus.mem_ready = (i % 3 == 2);
            @(negedge clk);
            check("t2_mem_rd", 32'(bus.mem_rd), 32'h1);
            check("t2_mem_addr", bus.mem_addr, 32'h4 + 32'(i / 3));
        end
        step();
        bus.ce        = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("t2_valid", 32'(bus.inst_valid), 32'h1);
        check("t2_inst", bus.inst, mem_word(32'h4));
        check("t2_inst_pc", bus.inst_pc, 32'h4);

        // Test 3: misaligned pc=6 fetches 0x4..0x7.
        step();
        bus.ce = 1'b1;
        bus.pc = 32'h6;
        wait_valid(20, n);
        bus.ce = 1'b0;
        @(negedge clk);
        check("t3_inst_pc", bus.inst_pc, 32'h4);
        check("t3_inst", bus.inst, mem_word(32'h4));

        // Test 4: IF/ID stalled for 3 DONE cycles.
        step();
        bus.ce    = 1'b1;
        bus.pc    = 32'h10;
        bus.stall = 6'b000010;
        wait_valid(20, n);
        w = mem_word(32'h10);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                bus.stall = 6'b000000;
                bus.ce    = 1'b0;
            end
            @(negedge clk);
            check("t4_hold_valid", 32'(bus.inst_valid), 32'h1);
            check("t4_hold_inst", bus.inst, w);
            check("t4_hold_pc", bus.inst_pc, 32'h10);
            step();
        end
        @(negedge clk);
        check("t4_release", 32'(bus.inst_valid), 32'h0);

        // Test 5: reset after two accepted bytes (rst and mem_ready together).
        step();
        bus.ce = 1'b1;
        bus.pc = 32'h20;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst    = 1'b0;
        bus.ce = 1'b1;
        @(negedge clk);
        check("t5_mem_rd", 32'(bus.mem_rd), 32'h0);
        check("t5_valid", 32'(bus.inst_valid), 32'h0);
        check("t5_inst", bus.inst, 32'h0);
        wait_valid(20, n);
        bus.ce = 1'b0;
        @(negedge clk);
        check("t5_refetch", bus.inst, mem_word(32'h20));

        // Address at the top of the space.
        step();
        bus.ce = 1'b1;
        bus.pc = 32'hFFFF_FFFD;
        wait_valid(20, n);
        bus.ce = 1'b0;
        @(negedge clk);
        check("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
        check("wrap_inst", bus.inst, mem_word(32'hFFFF_FFFC));

        // Test 6: same pc=8 fetched twice in succession.
        step();
        bus.ce = 1'b1;
        bus.pc = 32'h8;
        wait_valid(20, n);
        step();
        n     = 0;
        beats = 0;
        while (!bus.inst_valid && n < 20) begin
            if (bus.mem_rd) beats++;
            step();
            n++;
        end
        bus.ce = 1'b0;
`ifdef FETCH_BUF_EN
        check("t6_beats", 32'(beats), 32'd0);
        check("t6_latency", 32'(n), 32'd1);
`else
        check("t6_beats", 32'(beats), 32'd4);
        check("t6_latency", 32'(n), 32'd5);
`endif
        @(negedge clk);
        check("t6_inst", bus.inst, mem_word(32'h8));

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            step();
            rst           = ($urandom_range(0, 149) == 0);
            bus.ce        = ($urandom_range(0, 9) < 7);
            bus.mem_ready = ($urandom_range(0, 9) < 7);
            bus.stall     = 6'($urandom);
            if ($urandom_range(0, 9) == 0)
                bus.pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                bus.pc = 32'($urandom_range(0, 63));
        end
        step();
        rst    = 1'b0;
        bus.ce = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
